// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-port load/store sequencer.
// Op codes, size codes, state encoding and small alignment helpers.
package dmem_ctrl_pkg;

    localparam logic [1:0] MEM_DISABLE   = 2'b00;
    localparam logic [1:0] MEM_READ_SEXT = 2'b01;
    localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
    localparam logic [1:0] MEM_WRITE     = 2'b11;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_BEAT2 = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  size;
        logic [1:0]  off;
        logic [29:0] word;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [3:0] byte_mask(input logic [1:0] size);
        logic [3:0] m;
        unique case (1'b1)
            size == SZ_BYTE: m = 4'b0001;
            size == SZ_HALF: m = 4'b0011;
            default:         m = 4'b1111;
        endcase
        return m;
    endfunction

    // Size code 11 behaves as a word.
    function automatic logic crosses(input logic [1:0] off,
                                     input logic [1:0] size);
        logic [2:0] n;
        unique case (1'b1)
            size == SZ_BYTE: n = 3'd1;
            size == SZ_HALF: n = 3'd2;
            default:         n = 3'd4;
        endcase
        return ({1'b0, off} + n) > 3'd4;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Bundle of CPU request/response, loader and RAM port B signals.
// master = environment (CPU, loader, RAM), slave = controller.
interface dmem_ctrl_if;

    logic        req_valid;
    logic [1:0]  req_op;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        ldr_valid;
    logic [31:0] ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_ready;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [3:0]  ram_we;
    logic [31:0] ram_dout;

    modport master (
        output req_valid, req_op, req_size, req_addr, req_wdata,
        output ldr_valid, ldr_addr, ldr_wdata, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, ldr_ready,
        input  ram_addr, ram_din, ram_we
    );

    modport slave (
        input  req_valid, req_op, req_size, req_addr, req_wdata,
        input  ldr_valid, ldr_addr, ldr_wdata, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, ldr_ready,
        output ram_addr, ram_din, ram_we
    );

endinterface

// File: rtl/dmem_align.sv
// Byte-lane alignment: store lane enables/data over a word pair and
// load extraction with sign/zero extension. Purely combinational.
module dmem_align
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic [1:0]  op,
    input  logic [31:0] wdata,
    input  logic [63:0] rpair,
    output logic [7:0]  be,
    output logic [63:0] wshift,
    output logic [31:0] ldata
);

    logic [5:0]  sh;
    logic [31:0] raw;
    logic        sext;

    assign sh     = {off, 3'b000};
    assign be     = {4'b0000, byte_mask(size)} << off;
    assign wshift = {32'b0, wdata} << sh;
    assign raw    = 32'(rpair >> sh);
    assign sext   = op == MEM_READ_SEXT;

    always_comb begin
        ldata = '0;
        if (op == MEM_READ_SEXT || op == MEM_READ_ZEXT) begin
            unique case (1'b1)
                size == SZ_BYTE:
                    ldata = {{24{sext & raw[7]}}, raw[7:0]};
                size == SZ_HALF:
                    ldata = {{16{sext & raw[15]}}, raw[15:0]};
                default:
                    ldata = raw;
            endcase
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer and loader arbiter for data RAM port B.
// Misaligned accesses take two word beats; the loader wins in IDLE.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    dmem_ctrl_if.slave  bus
);

    logic [1:0]  state;
    req_t        cur_q;
    logic        cross_q;
    logic [31:0] word0_q;
    logic [31:0] rdata_q;

    logic        idle, ldr_go, accept, go, done, beat2;
    logic [31:0] req_word, ldr_word;
    logic [1:0]  a_off, a_size, a_op;
    logic [31:0] a_wdata;
    logic [63:0] rpair, wshift;
    logic [7:0]  be;
    logic [31:0] ldata;

    assign idle     = state == ST_IDLE && !reset;
    assign done     = state == ST_DONE && !reset;
    assign beat2    = state == ST_BEAT2 && !reset;
    assign ldr_go   = idle && bus.ldr_valid;
    assign accept   = idle && !bus.ldr_valid && bus.req_valid;
    assign go       = accept && bus.req_op != MEM_DISABLE;
    assign req_word = bus.req_addr & 32'hFFFF_FFFC;
    assign ldr_word = bus.ldr_addr & 32'hFFFF_FFFC;

    assign bus.ldr_ready = ldr_go;
    assign bus.req_ready = idle && !bus.ldr_valid;
    assign bus.rsp_valid = done;
    assign bus.rsp_rdata = done ? ldata : rdata_q;

    // Live request fields in the accept cycle, latched ones afterwards.
    assign a_off   = idle ? bus.req_addr[1:0] : cur_q.off;
    assign a_size  = idle ? bus.req_size : cur_q.size;
    assign a_op    = idle ? bus.req_op : cur_q.op;
    assign a_wdata = idle ? bus.req_wdata : cur_q.wdata;
    assign rpair   = cross_q ? {bus.ram_dout, word0_q}
                             : {32'b0, bus.ram_dout};

    dmem_align u_align (
        .off    (a_off),
        .size   (a_size),
        .op     (a_op),
        .wdata  (a_wdata),
        .rpair  (rpair),
        .be     (be),
        .wshift (wshift),
        .ldata  (ldata)
    );

    always_comb begin
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        bus.ram_we   = '0;
        if (ldr_go) begin
            bus.ram_addr = ldr_word;
            bus.ram_din  = bus.ldr_wdata;
            bus.ram_we   = 4'b1111;
        end else if (go) begin
            bus.ram_addr = req_word;
            if (bus.req_op == MEM_WRITE) begin
                bus.ram_we  = be[3:0];
                bus.ram_din = wshift[31:0];
            end
        end else if (beat2) begin
            bus.ram_addr = {cur_q.word + 30'd1, 2'b00};
            if (cur_q.op == MEM_WRITE) begin
                bus.ram_we  = be[7:4];
                bus.ram_din = wshift[63:32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cur_q   <= '0;
            cross_q <= 1'b0;
            word0_q <= '0;
            rdata_q <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        cur_q.op    <= bus.req_op;
                        cur_q.size  <= bus.req_size;
                        cur_q.off   <= bus.req_addr[1:0];
                        cur_q.word  <= req_word[31:2];
                        cur_q.wdata <= bus.req_wdata;
                        cross_q <= crosses(bus.req_addr[1:0],
                                           bus.req_size);
                        state <= crosses(bus.req_addr[1:0],
                                         bus.req_size)
                                 ? ST_BEAT2 : ST_DONE;
                    end
                end
                ST_BEAT2: begin
                    word0_q <= bus.ram_dout;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    rdata_q <= ldata;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed table, corner sequences,
// and random loads/stores against a byte-addressed reference memory.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dmem_ctrl_if bus();

    dmem_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read word RAM standing in for port B.
    logic [31:0] ram [logic [29:0]];

    function automatic logic [31:0] ram_rd(input logic [29:0] i);
        return ram.exists(i) ? ram[i] : 32'h0;
    endfunction

    always @(posedge clk) begin
        logic [31:0] w;
        w = ram_rd(bus.ram_addr[31:2]);
        bus.ram_dout <= w;
        for (int b = 0; b < 4; b++)
            if (bus.ram_we[b])
                w[8*b +: 8] = bus.ram_din[8*b +: 8];
        ram[bus.ram_addr[31:2]] = w;
    end

    // Byte-level reference memory for the random phase.
    logic [7:0] rmem [logic [31:0]];

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : 8'h0;
    endfunction

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] b1_addr, b1_din, b2_addr, b2_din;
    logic [3:0]  b1_we, b2_we;

    task automatic cpu_op(input logic [1:0] op,
                          input logic [1:0] sz,
                          input logic [31:0] a,
                          input logic [31:0] wd,
                          output logic [31:0] rd,
                          output int lat);
        int w;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_size  = sz;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) chk("accept_timeout", 32'h0, 32'h1);
        b1_addr = bus.ram_addr;
        b1_we   = bus.ram_we;
        b1_din  = bus.ram_din;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        bus.req_addr  = $urandom;
        lat = 0;
        rd  = 32'hX;
        while (lat < 4) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                b2_addr = bus.ram_addr;
                b2_we   = bus.ram_we;
                b2_din  = bus.ram_din;
            end
            if (bus.rsp_valid) begin
                rd = bus.rsp_rdata;
                break;
            end
        end
    endtask

    task automatic ldr_write(input logic [31:0] a,
                             input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.ldr_valid = 1'b1;
        bus.ldr_addr  = a;
        bus.ldr_wdata = d;
        @(negedge clk);
        chk("ldr_ready", 32'(bus.ldr_ready), 32'h1);
        chk("ldr_we", 32'(bus.ram_we), 32'hF);
        chk("ldr_addr", bus.ram_addr, a & 32'hFFFF_FFFC);
        chk("ldr_din", bus.ram_din, d);
        @(posedge clk);
        #1;
        bus.ldr_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, a, wd, exp;
        logic [63:0] v;
        logic [1:0]  op, sz;
        int          lat, n, exp_lat;

        checks = 0;
        errors = 0;

        tbl[0]  = '{MEM_WRITE,     SZ_WORD, 32'h100, 32'hDEADBEEF,
                    32'h0, 1};
        tbl[1]  = '{MEM_READ_SEXT, SZ_WORD, 32'h100, 32'h0,
                    32'hDEADBEEF, 1};
        tbl[2]  = '{MEM_READ_SEXT, SZ_BYTE, 32'h203, 32'h0,
                    32'hFFFFFF80, 1};
        tbl[3]  = '{MEM_READ_ZEXT, SZ_BYTE, 32'h203, 32'h0,
                    32'h00000080, 1};
        tbl[4]  = '{MEM_READ_SEXT, SZ_HALF, 32'h202, 32'h0,
                    32'hFFFF80F0, 1};
        tbl[5]  = '{MEM_READ_SEXT, SZ_BYTE, 32'h201, 32'h0,
                    32'h0000007F, 1};
        tbl[6]  = '{MEM_READ_SEXT, SZ_WORD, 32'h105, 32'h0,
                    32'h11223344, 2};
        tbl[7]  = '{MEM_WRITE,     SZ_WORD, 32'h100, 32'h000000CD,
                    32'h0, 1};
        tbl[8]  = '{MEM_READ_ZEXT, SZ_HALF, 32'h0FF, 32'h0,
                    32'h0000CDAB, 2};
        tbl[9]  = '{MEM_READ_SEXT, SZ_BYTE, 32'h106, 32'h0,
                    32'h00000033, 1};
        tbl[10] = '{MEM_READ_SEXT, SZ_HALF, 32'h107, 32'h0,
                    32'h00001122, 2};
        tbl[11] = '{MEM_READ_ZEXT, 2'b11,   32'h104, 32'h0,
                    32'h22334400, 1};

        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_op    = MEM_WRITE;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h1;
        bus.ldr_valid = 1'b1;
        bus.ldr_addr  = 32'h20;
        bus.ldr_wdata = 32'h2;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_ldr_ready", 32'(bus.ldr_ready), 32'h0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.ldr_valid = 1'b0;
        @(negedge clk);
        chk("idle_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("idle_ram_addr", bus.ram_addr, 32'h0);
        chk("idle_ram_din", bus.ram_din, 32'h0);
        chk("idle_ram_we", 32'(bus.ram_we), 32'h0);
        chk("idle_req_ready", 32'(bus.req_ready), 32'h1);

        ldr_write(32'h200, 32'h80F07F01);
        ldr_write(32'h0FE, 32'hAB000000);
        ldr_write(32'h304, 32'h55555555);
        ldr_write(32'h308, 32'h55555555);

        cpu_op(MEM_WRITE, SZ_WORD, 32'h105, 32'h11223344, rd, lat);
        chk("mis_b1_addr", b1_addr, 32'h104);
        chk("mis_b1_we", 32'(b1_we), 32'hE);
        chk("mis_b1_din", b1_din, 32'h22334400);
        chk("mis_b2_addr", b2_addr, 32'h108);
        chk("mis_b2_we", 32'(b2_we), 32'h1);
        chk("mis_b2_din", b2_din, 32'h00000011);
        chk("mis_lat", 32'(lat), 32'h2);

        foreach (tbl[i]) begin
            cpu_op(tbl[i].op, tbl[i].size, tbl[i].addr,
                   tbl[i].wdata, rd, lat);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
            chk($sformatf("tbl%0d_lat", i), 32'(lat),
                32'(tbl[i].lat));
            if (i == 0)
                chk("tbl0_we", 32'(b1_we), 32'hF);
            @(negedge clk);
            chk($sformatf("tbl%0d_pulse", i),
                32'(bus.rsp_valid), 32'h0);
            chk($sformatf("tbl%0d_hold", i), bus.rsp_rdata,
                tbl[i].exp);
        end

        cpu_op(MEM_WRITE, SZ_WORD, 32'hFFFFFFFE, 32'hCAFEF00D,
               rd, lat);
        chk("wrap_b1_addr", b1_addr, 32'hFFFFFFFC);
        chk("wrap_b1_we", 32'(b1_we), 32'hC);
        chk("wrap_b1_din", b1_din, 32'hF00D0000);
        chk("wrap_b2_addr", b2_addr, 32'h0);
        chk("wrap_b2_we", 32'(b2_we), 32'h3);
        chk("wrap_b2_din", b2_din, 32'h0000CAFE);
        cpu_op(MEM_READ_ZEXT, SZ_WORD, 32'hFFFFFFFE, 32'h0,
               rd, lat);
        chk("wrap_load", rd, 32'hCAFEF00D);
        chk("wrap_lat", 32'(lat), 32'h2);

        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = MEM_DISABLE;
        @(negedge clk);
        chk("dis_ready", 32'(bus.req_ready), 32'h1);
        chk("dis_we", 32'(bus.ram_we), 32'h0);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rd = 32'h0;
        repeat (3) begin
            @(negedge clk);
            rd = rd | 32'(bus.rsp_valid);
        end
        chk("dis_no_rsp", rd, 32'h0);

        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = MEM_READ_ZEXT;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'h400;
        bus.ldr_valid = 1'b1;
        bus.ldr_addr  = 32'h403;
        bus.ldr_wdata = 32'h12345678;
        @(negedge clk);
        chk("pri_ldr_ready", 32'(bus.ldr_ready), 32'h1);
        chk("pri_req_ready", 32'(bus.req_ready), 32'h0);
        chk("pri_we", 32'(bus.ram_we), 32'hF);
        chk("pri_addr", bus.ram_addr, 32'h400);
        @(posedge clk);
        #1;
        bus.ldr_valid = 1'b0;
        @(negedge clk);
        chk("pri_req_after", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("pri_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        chk("pri_rdata", bus.rsp_rdata, 32'h12345678);

        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_op    = MEM_WRITE;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'h305;
        bus.req_wdata = 32'hA1B2C3D4;
        @(negedge clk);
        chk("rs_accept", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rs_we", 32'(bus.ram_we), 32'h0);
        chk("rs_rsp", 32'(bus.rsp_valid), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rs_ready", 32'(bus.req_ready), 32'h1);
        chk("rs_rsp_after", 32'(bus.rsp_valid), 32'h0);
        cpu_op(MEM_READ_ZEXT, SZ_WORD, 32'h304, 32'h0, rd, lat);
        chk("rs_beat1", rd, 32'hB2C3D455);
        cpu_op(MEM_READ_ZEXT, SZ_WORD, 32'h308, 32'h0, rd, lat);
        chk("rs_beat2", rd, 32'h55555555);

        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(1, 3));
            sz = 2'($urandom_range(0, 3));
            a  = 32'h800 + $urandom_range(0, 31);
            wd = $urandom;
            n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            exp_lat = ((a % 4) + n > 4) ? 2 : 1;
            exp = 32'h0;
            if (op != MEM_WRITE) begin
                v = 64'h0;
                for (int k = 0; k < n; k++)
                    v = v | (64'(ref_rd(a + k)) << (8 * k));
                if (op == MEM_READ_SEXT && v[8*n-1])
                    v = v | ~((64'h1 << (8 * n)) - 64'h1);
                exp = v[31:0];
            end else begin
                for (int k = 0; k < n; k++)
                    rmem[a + k] = 8'(wd >> (8 * k));
            end
            cpu_op(op, sz, a, wd, rd, lat);
            chk($sformatf("rand%0d_rdata", i), rd, exp);
            chk($sformatf("rand%0d_lat", i), 32'(lat),
                32'(exp_lat));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
